// File: rtl/seed_sbox1_inv_seq_if.sv
// rtl/seed_sbox1_inv_seq_if.sv - valid/ready handshake bundle for the SEED S1 sequential engine
//
// Signals:
//   in_valid  : producer -> engine, in_data/mode valid
//   in_ready  : engine -> producer, engine can accept (IDLE only)
//   in_data   : producer -> engine, byte to transform
//   mode      : producer -> engine, 0 = S1^-1, 1 = S1 forward
//   out_valid : engine -> consumer, result valid, held until out_ready
//   out_ready : consumer -> engine, consumer accepts result
//   out_data  : engine -> consumer, transformed byte
//
// Modports:
//   master : the side that issues bytes and consumes results
//   slave  : the S-box engine

interface seed_sbox1_inv_seq_if;

    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       mode;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;

    modport master (
        output in_valid,
        output in_data,
        output mode,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  mode,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

endinterface

// File: rtl/seed_sbox1_inv_seq.sv
// rtl/seed_sbox1_inv_seq.sv - sequential SEED S1 / S1^-1 evaluator using square-and-multiply in GF(2^8)
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seed_sbox1_inv_seq_if.slave (in_valid/in_ready/in_data/mode,
//           out_valid/out_ready/out_data)
//
// Forward:  S1(x)    = A1(x^247) ^ AFF_C
// Inverse:  S1^-1(y) = A1inv(y ^ AFF_C)^223      (247 * 223 = 1 mod 255)
// One exponentiation of 8 square-and-multiply steps is run MSB first, so the
// result is registered 8 clocks after the accept edge and held in DONE.

module seed_sbox1_inv_seq #(
    parameter logic [7:0] POLY  = 8'h63,
    parameter logic [7:0] AFF_C = 8'hA9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seed_sbox1_inv_seq_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXP  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [7:0] E_FWD = 8'hF7;
    localparam logic [7:0] E_INV = 8'hDF;

    // Reduce a degree-14 carry-less product modulo x^8 + POLY. Bits are
    // cleared from the top down, so each step only touches lower bits.
    function automatic logic [7:0] gf_reduce(input logic [14:0] p);
        logic [14:0] t;
        t = p;
        for (int i = 14; i >= 8; i--) begin
            if (t[i]) begin
                t = t ^ ({6'b0, 1'b1, POLY} << (i - 8));
            end
        end
        return t[7:0];
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ ({7'b0, a} << i);
            end
        end
        return gf_reduce(p);
    endfunction

    // Squaring in characteristic 2 is linear: just spread the bits apart.
    function automatic logic [7:0] gf_sq(input logic [7:0] a);
        logic [14:0] p;
        p = 15'h0;
        for (int i = 0; i < 8; i++) begin
            p[2*i] = a[i];
        end
        return gf_reduce(p);
    endfunction

    function automatic logic [7:0] a1_fwd(input logic [7:0] p);
        logic [7:0] q;
        q[7] = p[7] ^ p[3] ^ p[1];
        q[6] = p[7] ^ p[6] ^ p[5] ^ p[4] ^ p[3] ^ p[2] ^ p[1];
        q[5] = p[7] ^ p[2] ^ p[0];
        q[4] = p[6] ^ p[1];
        q[3] = p[6] ^ p[2] ^ p[0];
        q[2] = p[5] ^ p[0];
        q[1] = p[7] ^ p[3];
        q[0] = p[4] ^ p[2];
        return q;
    endfunction

    // GF(2) inverse of the A1 matrix, solved by back-substitution.
    function automatic logic [7:0] a1_inv(input logic [7:0] q);
        logic [7:0] p;
        p[7] = q[7] ^ q[5] ^ q[4] ^ q[3] ^ q[1];
        p[6] = q[7] ^ q[4] ^ q[1];
        p[5] = q[6] ^ q[4] ^ q[1] ^ q[0];
        p[4] = q[7] ^ q[6] ^ q[3] ^ q[2];
        p[3] = q[7] ^ q[5] ^ q[4] ^ q[3];
        p[2] = q[7] ^ q[6] ^ q[3] ^ q[2] ^ q[0];
        p[1] = q[7] ^ q[1];
        p[0] = q[6] ^ q[4] ^ q[2] ^ q[1] ^ q[0];
        return p;
    endfunction

    logic [1:0] state;
    logic [7:0] r;
    logic [7:0] b;
    logic [2:0] cnt;
    logic       mode_q;
    logic [7:0] out_data_q;

    logic [7:0] exp_e;
    logic       e_bit;
    logic [7:0] r_sq;
    logic [7:0] mul_op;
    logic [7:0] r_next;
    logic [7:0] b_load;
    logic [7:0] result;
    logic       accept;

    assign exp_e  = mode_q ? E_FWD : E_INV;
    assign e_bit  = exp_e[cnt];
    assign r_sq   = gf_sq(r);
    // The single multiplier always runs; a zero exponent bit multiplies by 1.
    assign mul_op = e_bit ? b : 8'h01;
    assign r_next = gf_mul(r_sq, mul_op);

    assign b_load = bus.mode ? bus.in_data : a1_inv(bus.in_data ^ AFF_C);
    assign result = mode_q ? (a1_fwd(r_next) ^ AFF_C) : r_next;

    assign accept        = bus.in_valid && (state == S_IDLE);
    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.out_data  = out_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            r          <= 8'h00;
            b          <= 8'h00;
            cnt        <= 3'd0;
            mode_q     <= 1'b0;
            out_data_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        b      <= b_load;
                        mode_q <= bus.mode;
                        r      <= 8'h01;
                        cnt    <= 3'd7;
                        state  <= S_EXP;
                    end
                end
                S_EXP: begin
                    r <= r_next;
                    if (cnt == 3'd0) begin
                        out_data_q <= result;
                        state      <= S_DONE;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seed_sbox1_inv_seq.sv
// tb/tb_seed_sbox1_inv_seq.sv - self-checking bench for seed_sbox1_inv_seq

module tb_seed_sbox1_inv_seq;

    logic clk;
    logic rst_n;

    seed_sbox1_inv_seq_if bus ();

    seed_sbox1_inv_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] s1_tab [256];
    logic [7:0] inv_tab [256];

    typedef struct {
        logic       m;
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference arithmetic: xtime-based multiply, independent of the RTL form.
    function automatic logic [7:0] m_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h63;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] m_a1(input logic [7:0] p);
        logic [7:0] q;
        q[7] = p[7] ^ p[3] ^ p[1];
        q[6] = p[7] ^ p[6] ^ p[5] ^ p[4] ^ p[3] ^ p[2] ^ p[1];
        q[5] = p[7] ^ p[2] ^ p[0];
        q[4] = p[6] ^ p[1];
        q[3] = p[6] ^ p[2] ^ p[0];
        q[2] = p[5] ^ p[0];
        q[1] = p[7] ^ p[3];
        q[0] = p[4] ^ p[2];
        return q;
    endfunction

    task automatic do_op(input logic m, input logic [7:0] d, output logic [7:0] res, output int lat);
        int n;
        @(negedge clk);
        bus.mode     = m;
        bus.in_data  = d;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        bus.mode     = ~m;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.out_data;
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] res;
        logic [7:0] f;
        logic [7:0] g;
        logic [7:0] p;
        int         lat;
        int         n;
        int         err;
        int         lerr;
        int         dup;
        int         inverr;
        logic       seen [256];
        logic [7:0] sd [16];
        logic       sm [16];
        logic [7:0] sexp [16];
        logic       acc;
        logic       tak;
        logic [7:0] od;
        int         sent;
        int         got;
        int         last;
        int         ierr;

        for (int x = 0; x < 256; x++) begin
            p = 8'h01;
            for (int k = 0; k < 247; k++) p = m_mul(p, 8'(x));
            s1_tab[x] = m_a1(p) ^ 8'hA9;
        end
        for (int x = 0; x < 256; x++) inv_tab[s1_tab[x]] = 8'(x);

        vt[0] = '{1'b1, 8'h00, 8'hA9};
        vt[1] = '{1'b0, 8'hA9, 8'h00};
        vt[2] = '{1'b0, 8'h85, 8'h01};
        vt[3] = '{1'b0, 8'h00, inv_tab[0]};
        vt[4] = '{1'b1, 8'hFF, s1_tab[255]};
        vt[5] = '{1'b1, 8'h01, 8'h85};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.mode      = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_out_data", 32'(bus.out_data), 32'h00);
        rst_n = 1'b1;

        // Directed vectors
        for (int i = 0; i < 6; i++) begin
            do_op(vt[i].m, vt[i].din, res, lat);
            check($sformatf("vec%0d_data", i), 32'(res), 32'(vt[i].dout));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'd8);
        end

        // Reset in the middle of EXP, with cnt at 4; out_data holds 85 here
        @(negedge clk);
        bus.mode = 1'b0; bus.in_data = 8'hA9; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midexp_busy", 32'({bus.in_ready, bus.out_valid}), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        check("midrst_out_data", 32'(bus.out_data), 32'h00);
        @(negedge clk);
        rst_n = 1'b1;
        err = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) err++;
        end
        check("midrst_no_partial", 32'(err), 32'd0);
        do_op(1'b0, 8'h85, res, lat);
        check("post_reset_data", 32'(res), 32'h01);
        check("post_reset_latency", 32'(lat), 32'd8);

        // Backpressure in DONE
        @(negedge clk);
        bus.mode = 1'b0; bus.in_data = 8'h85; bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_latency", 32'(n), 32'd8);
        err = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01 || bus.in_ready !== 1'b0) err++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = 8'($urandom);
            bus.mode     = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h01) err++;
        check("bp_stable", 32'(err), 32'd0);
        // Simultaneous in_valid and out_ready in DONE: only the output moves
        bus.in_valid = 1'b1; bus.mode = 1'b1; bus.in_data = 8'h01; bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check("bp_release_not_accepted", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("bp_next_accepted", 32'(bus.in_ready), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("bp_next_latency", 32'(n), 32'd8);
        check("bp_next_data", 32'(bus.out_data), 32'h85);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("bp_back_idle", 32'(bus.in_ready), 32'd1);

        // Exhaustive forward and round trip
        lerr = 0;
        for (int x = 0; x < 256; x++) begin
            do_op(1'b1, 8'(x), f, lat);
            if (lat != 8) lerr++;
            check($sformatf("fwd_%02h", x), 32'(f), 32'(s1_tab[x]));
            do_op(1'b0, f, g, lat);
            if (lat != 8) lerr++;
            check($sformatf("roundtrip_%02h", x), 32'(g), 32'(x));
        end
        check("sweep1_latency_errors", 32'(lerr), 32'd0);

        // Inverse outputs over all inputs form a permutation
        for (int y = 0; y < 256; y++) seen[y] = 1'b0;
        dup = 0; inverr = 0; lerr = 0;
        for (int y = 0; y < 256; y++) begin
            do_op(1'b0, 8'(y), g, lat);
            if (lat != 8) lerr++;
            if (seen[g]) dup++;
            seen[g] = 1'b1;
            if (g !== inv_tab[y]) inverr++;
        end
        check("inv_perm_duplicates", 32'(dup), 32'd0);
        check("inv_model_errors", 32'(inverr), 32'd0);
        check("sweep2_latency_errors", 32'(lerr), 32'd0);

        // Streaming with in_valid and out_ready tied high
        for (int i = 0; i < 16; i++) begin
            sd[i]   = 8'($urandom);
            sm[i]   = 1'($urandom_range(0, 1));
            sexp[i] = sm[i] ? s1_tab[sd[i]] : inv_tab[sd[i]];
        end
        @(negedge clk);
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        bus.in_data = sd[0]; bus.mode = sm[0];
        sent = 0; got = 0; last = -1; ierr = 0;
        for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
            acc = bus.in_valid && bus.in_ready;
            tak = bus.out_valid;
            od  = bus.out_data;
            @(posedge clk);
            #1;
            if (tak) begin
                check($sformatf("stream_%0d", got), 32'(od), 32'(sexp[got]));
                if (got > 0 && cyc - last != 10) ierr++;
                last = cyc;
                got++;
            end
            if (acc) begin
                sent++;
                if (sent < 16) begin
                    bus.in_data = sd[sent];
                    bus.mode    = sm[sent];
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        check("stream_count", 32'(got), 32'd16);
        check("stream_interval_errors", 32'(ierr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seed_sbox1_inv_seq.md
Name: seed_sbox1_inv_seq

Overview:
- Sequential engine for the SEED S1 substitution, built mainly for its inverse, S1^-1.
- Uses one GF(2^8) multiplier plus a squarer in a square-and-multiply loop, not a table.
- Mode input also selects forward S1 through the same datapath, so the engine can self-check against the combinational S1.
- Sits beside the serialized SEED datapath as a shared, area-lean S-box evaluator with a valid/ready interface on both sides.

Parameters:
POLY, 8'h63, low 8 bits of the field polynomial x^8+x^6+x^5+x+1 (SEED field); reduction constant.
AFF_C, 8'hA9, affine constant (169) XORed at the S1 output.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data/mode valid.
in_ready  output  1  engine can accept; high only in IDLE.
in_data  input  8  byte to transform.
mode  input  1  0 = S1^-1, 1 = S1 forward; sampled with in_data.
out_valid  output  1  result valid; held until out_ready.
out_ready  input  1  consumer accepts result.
out_data  output  8  transformed byte.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1; out_valid=0; out_data=8'h00.
  - Internal r, b, cnt, mode_q cleared.
  - Reset mid-operation aborts the operation; no partial result is ever presented.
- Linear map A1, p to q:
  - q7=p7^p3^p1; q6=p7^p6^p5^p4^p3^p2^p1; q5=p7^p2^p0; q4=p6^p1
  - q3=p6^p2^p0; q2=p5^p0; q1=p7^p3; q0=p4^p2
- A1inv: the unique GF(2) inverse matrix of A1, hard-wired XOR network. Required property: A1inv(A1(p))=p for all 256 p.
- Math:
  - Forward: S1(x) = A1(x^247) ^ AFF_C.
  - Inverse: S1^-1(y) = (A1inv(y ^ AFF_C))^223. Valid because 247*223 = 1 mod 255.
  - 0 maps through naturally (0^e = 0); no special case.
- Exponent E: 8'hF7 (247) when mode_q=1; 8'hDF (223) when mode_q=0.
- States:
  - IDLE:
    - On in_valid & in_ready, capture:
      - b = mode ? in_data : A1inv(in_data ^ AFF_C)
      - mode_q = mode; r = 8'h01; cnt = 7
    - Go to EXP.
  - EXP:
    - Each cycle: r = sq(r) * (E[cnt] ? b : 1).
    - sq is combinational squaring mod POLY; * is combinational GF multiply mod POLY.
    - cnt decrements.
    - After the cnt=0 iteration (8 cycles in EXP), register out_data and go to DONE:
      - out_data = mode_q ? A1(r_next) ^ AFF_C : r_next
  - DONE:
    - out_valid=1; out_data held stable.
    - On out_ready go to IDLE; out_valid=0 next cycle.
- Timing:
  - Latency: out_valid rises 8 clocks after the accept edge.
  - Minimum issue interval is 10 cycles with out_ready tied high.
- Handshake:
  - in_ready=0 in EXP and DONE; in_valid there is ignored and in_data is not sampled.
  - in_data and mode may change freely after acceptance.
  - out_ready while out_valid=0 has no effect.
  - Simultaneous in_valid and out_ready in DONE: only the output is consumed; the input is accepted no earlier than the next cycle, in IDLE.
- All arithmetic is 8-bit GF(2^8); no integer carries. cnt is 3 bits and does not wrap past 0 (the state exits).

Test Plan:
- Reset asserted mid-EXP (cnt=4) -> out_valid=0, in_ready=1, out_data=00 asynchronously; the next op completes correctly.
- mode=0, in_data=A9 -> out_valid 8 cycles after accept, out_data=00. Also mode=0, in_data=85 -> 01.
- mode=1, in_data=00 -> A9; mode=1, in_data=01 -> 85 (matches SEED S1 table entries 0 and 1).
- Exhaustive round-trip over x=00..FF:
  - forward then inverse returns x;
  - forward output equals the combinational S1 for all 256 values;
  - the inverse outputs form a permutation.
- Backpressure: hold out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable, in_ready=0, extra in_valid pulses ignored. Release -> one transfer, then back to IDLE.
- Streaming with in_valid and out_ready tied high, 16 random bytes -> one result per 10 cycles, in order, all matching the model.
